// File: rtl/comparator_multimode_pipe.sv
// Purpose : LANES-wide multi-relation (GT/GE/LT/LE/EQ/NE) comparator, signed or unsigned, with any/all reductions and an all-lanes persistence flag.
// Latency : 2 cycles from accept to valid_o; throughput 1 transaction per cycle.
// Backpressure: ready_o drops only when both stages are full and ready_i is low; outputs hold stable while stalled.
module comparator_multimode_pipe #(
    parameter int DATA_WIDTH    = 13,
    parameter int LANES         = 4,
    parameter int PERSIST_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clear_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [LANES*DATA_WIDTH-1:0]   A_i,
    input  logic [LANES*DATA_WIDTH-1:0]   B_i,
    input  logic [2:0]                    mode_i,
    input  logic                          signed_i,
    input  logic [PERSIST_WIDTH-1:0]      persist_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [LANES-1:0]              result_o,
    output logic                          any_o,
    output logic                          all_o,
    output logic                          persist_hit_o
);

    localparam logic [2:0] MODE_GT = 3'd0;
    localparam logic [2:0] MODE_GE = 3'd1;
    localparam logic [2:0] MODE_LT = 3'd2;
    localparam logic [2:0] MODE_LE = 3'd3;
    localparam logic [2:0] MODE_EQ = 3'd4;
    localparam logic [2:0] MODE_NE = 3'd5;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single magnitude comparator serves both modes.
    localparam logic [DATA_WIDTH-1:0]    SIGN_MASK = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [PERSIST_WIDTH-1:0] CNT_MAX   = '1;

    // Stage 1 registers
    logic                        r_s1_vld;
    logic [LANES*DATA_WIDTH-1:0] r_s1_a;
    logic [LANES*DATA_WIDTH-1:0] r_s1_b;
    logic [2:0]                  r_s1_mode;
    logic                        r_s1_sgn;
    logic [PERSIST_WIDTH-1:0]    r_s1_persist;

    // Stage 2 (output) registers
    logic                        r_valid;
    logic [LANES-1:0]            r_result;
    logic                        r_any;
    logic                        r_all;
    logic                        r_hit;
    logic [PERSIST_WIDTH-1:0]    r_cnt;

    // Handshake and datapath wires
    logic                        w_accept;
    logic                        w_s2_load;
    logic [DATA_WIDTH-1:0]       w_sign_mask;
    logic [LANES-1:0]            w_result;
    logic                        w_any;
    logic                        w_all;
    logic [PERSIST_WIDTH-1:0]    w_cnt_next;
    logic                        w_hit;

    // Stage 2 can take a new transaction whenever it is empty or draining this cycle.
    assign w_s2_load = r_s1_vld & (~r_valid | ready_i);
    assign ready_o   = ~(r_s1_vld & r_valid & ~ready_i);
    // A transaction offered together with clear_i is discarded.
    assign w_accept  = valid_i & ready_o & ~clear_i;

    assign w_sign_mask = r_s1_sgn ? SIGN_MASK : '0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_a;
        logic [DATA_WIDTH-1:0] w_b;
        logic                  w_gt;
        logic                  w_eq;
        logic                  w_rel;

        assign w_a  = r_s1_a[k*DATA_WIDTH +: DATA_WIDTH] ^ w_sign_mask;
        assign w_b  = r_s1_b[k*DATA_WIDTH +: DATA_WIDTH] ^ w_sign_mask;
        assign w_gt = (w_a > w_b);
        assign w_eq = (w_a == w_b);

        // Pick the requested relation; reserved modes report false.
        always_comb begin
            w_rel = 1'b0;
            case (r_s1_mode)
                MODE_GT: w_rel = w_gt;
                MODE_GE: w_rel = w_gt | w_eq;
                MODE_LT: w_rel = ~w_gt & ~w_eq;
                MODE_LE: w_rel = ~w_gt;
                MODE_EQ: w_rel = w_eq;
                MODE_NE: w_rel = ~w_eq;
                default: w_rel = 1'b0;
            endcase
        end

        assign w_result[k] = w_rel;
    end

    assign w_any = |w_result;
    assign w_all = &w_result;

    // Saturating run-length of consecutive all-lanes-true transactions.
    always_comb begin
        w_cnt_next = '0;
        if (w_all) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
        end
    end

    // A zero threshold disables the flag entirely.
    assign w_hit = (r_s1_persist != '0) && (w_cnt_next >= r_s1_persist);

    // Stage 1: capture every field of an accepted transaction; empty once handed to stage 2.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_vld     <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_mode    <= '0;
            r_s1_sgn     <= 1'b0;
            r_s1_persist <= '0;
        end else if (clear_i) begin
            r_s1_vld     <= 1'b0;
        end else if (w_accept) begin
            r_s1_vld     <= 1'b1;
            r_s1_a       <= A_i;
            r_s1_b       <= B_i;
            r_s1_mode    <= mode_i;
            r_s1_sgn     <= signed_i;
            r_s1_persist <= persist_i;
        end else if (w_s2_load) begin
            r_s1_vld     <= 1'b0;
        end
    end

    // Stage 2: register compare results and persistence; hold everything while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_any    <= 1'b0;
            r_all    <= 1'b0;
            r_hit    <= 1'b0;
            r_cnt    <= '0;
        end else if (clear_i) begin
            r_valid  <= 1'b0;
            r_hit    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_s2_load) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_any    <= w_any;
            r_all    <= w_all;
            r_hit    <= w_hit;
            r_cnt    <= w_cnt_next;
        end else if (r_valid && ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign valid_o       = r_valid;
    assign result_o      = r_result;
    assign any_o         = r_any;
    assign all_o         = r_all;
    assign persist_hit_o = r_hit;

endmodule

// File: tb/tb_comparator_multimode_pipe.sv
// Purpose : self-checking bench for comparator_multimode_pipe (directed steps plus randomized stream).
// Latency : checks the 2-cycle accept-to-valid path and single-cycle throughput.
// Backpressure: stalls ready_i and checks hold, ordering and ready_o deassertion.
module tb_comparator_multimode_pipe;

    localparam int DW = 13;
    localparam int L  = 4;
    localparam int PW = 8;

    typedef struct packed {
        logic [L-1:0] res;
        logic         any;
        logic         all;
        logic         hit;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear_i;
    logic            valid_i;
    logic            ready_o;
    logic [L*DW-1:0] A_i;
    logic [L*DW-1:0] B_i;
    logic [2:0]      mode_i;
    logic            signed_i;
    logic [PW-1:0]   persist_i;
    logic            valid_o;
    logic            ready_i;
    logic [L-1:0]    result_o;
    logic            any_o;
    logic            all_o;
    logic            persist_hit_o;

    always #5 clk = ~clk;

    comparator_multimode_pipe #(
        .DATA_WIDTH   (DW),
        .LANES        (L),
        .PERSIST_WIDTH(PW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .A_i          (A_i),
        .B_i          (B_i),
        .mode_i       (mode_i),
        .signed_i     (signed_i),
        .persist_i    (persist_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .any_o        (any_o),
        .all_o        (all_o),
        .persist_hit_o(persist_hit_o)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           m_cnt = 0;
    exp_t         q[$];
    logic         hit_log[$];
    logic [L-1:0] res_log[$];
    logic         s_vld, s_rdy, s_any, s_all;
    logic [L-1:0] s_res;
    logic         prev_stall = 1'b0;
    exp_t         prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference relation using integer arithmetic on the decoded operand values.
    function automatic logic rel(input logic [2:0] m, input logic sg,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        int x, y;
        x = sg ? int'($signed(a)) : int'(a);
        y = sg ? int'($signed(b)) : int'(b);
        case (m)
            3'd0: return x >  y;
            3'd1: return x >= y;
            3'd2: return x <  y;
            3'd3: return x <= y;
            3'd4: return x == y;
            3'd5: return x != y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_model();
        exp_t e;
        int   mx;
        for (int k = 0; k < L; k++)
            e.res[k] = rel(mode_i, signed_i, A_i[k*DW +: DW], B_i[k*DW +: DW]);
        e.any = |e.res;
        e.all = &e.res;
        mx = (1 << PW) - 1;
        if (e.all) m_cnt = (m_cnt < mx) ? m_cnt + 1 : mx;
        else       m_cnt = 0;
        e.hit = (persist_i != 0) && (m_cnt >= int'(persist_i));
        q.push_back(e);
    endtask

    // One clock: sample/check at negedge, update the model, return at posedge+1.
    task automatic cyc();
        exp_t o, e;
        @(negedge clk);
        s_vld = valid_o; s_rdy = ready_o; s_res = result_o; s_any = any_o; s_all = all_o;
        o = {result_o, any_o, all_o, persist_hit_o};
        if (prev_stall && valid_o) chk("hold_stable", o, prev_out);
        if (valid_o && ready_i) begin
            chk("output_expected", (q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result", o.res, e.res);
                chk("any", o.any, e.any);
                chk("all", o.all, e.all);
                chk("persist_hit", o.hit, e.hit);
                hit_log.push_back(persist_hit_o);
                res_log.push_back(result_o);
            end
        end
        prev_stall = valid_o && !ready_i;
        prev_out   = o;
        if (rst_n && clear_i) begin
            q.delete(); m_cnt = 0; prev_stall = 1'b0;
        end else if (rst_n && valid_i && ready_o) begin
            push_model();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] b);
        A_i = {L{a}};
        B_i = {L{b}};
    endtask

    task automatic clear_logs();
        hit_log.delete();
        res_log.delete();
    endtask

    logic [L-1:0] sweep_exp [8] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [L-1:0] bp_exp    [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    logic         ph_exp    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int c, t;
        rst_n = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        A_i = '0; B_i = '0; mode_i = '0; signed_i = 1'b0; persist_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_any", any_o, 0);
        chk("rst_all", all_o, 0);
        chk("rst_hit", persist_hit_o, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", ready_o, 1);
        @(posedge clk);
        #1;

        // Latency: lane0 100>50, lane1 5>5, lane2 7>9, lane3 0>0
        A_i = {13'd0, 13'd7, 13'd5, 13'd100};
        B_i = {13'd0, 13'd9, 13'd5, 13'd50};
        mode_i = 3'd0; signed_i = 1'b0; persist_i = '0; valid_i = 1'b1;
        cyc();
        valid_i = 1'b0;
        cyc(); chk("lat_cycle1_valid", s_vld, 0);
        cyc(); chk("lat_cycle2_valid", s_vld, 1);
        chk("lat_result", s_res, 4'b0001);
        chk("lat_any", s_any, 1);
        chk("lat_all", s_all, 0);
        repeat (2) cyc();

        // Mode sweep on equal operands, including reserved modes
        clear_logs();
        set_all(13'd7, 13'd7); valid_i = 1'b1;
        for (int m = 0; m < 8; m++) begin
            mode_i = 3'(m);
            cyc();
        end
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("sweep_count", res_log.size(), 8);
        for (int m = 0; m < 8 && m < res_log.size(); m++) chk("sweep_mode", res_log[m], sweep_exp[m]);

        // Signed vs unsigned: -1 < 1 only when signed
        clear_logs();
        set_all(13'h1FFF, 13'h0001); mode_i = 3'd2; valid_i = 1'b1;
        signed_i = 1'b1; cyc();
        signed_i = 1'b0; cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("sign_count", res_log.size(), 2);
        if (res_log.size() == 2) begin
            chk("signed_lt", res_log[0], 4'hF);
            chk("unsigned_lt", res_log[1], 4'h0);
        end

        // Backpressure: 5 one-hot EQ transactions, ready_i low for 3 cycles
        clear_logs();
        mode_i = 3'd4; B_i = {13'd3, 13'd2, 13'd1, 13'd0};
        c = 0; t = 0;
        while (t < 5 && c < 50) begin
            ready_i = (c >= 3);
            A_i = {L{13'(t)}};
            valid_i = 1'b1;
            cyc();
            if (c == 2) chk("bp_ready_low", s_rdy, 0);
            if (s_rdy) t++;
            c++;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (4) cyc();
        chk("bp_count", res_log.size(), 5);
        for (int i = 0; i < 5 && i < res_log.size(); i++) chk("bp_order", res_log[i], bp_exp[i]);

        // Persistence threshold 3: four true, one false, two true
        clear_logs();
        set_all(13'd5, 13'd5); persist_i = 8'd3; valid_i = 1'b1;
        mode_i = 3'd1; repeat (4) cyc();
        mode_i = 3'd0; cyc();
        mode_i = 3'd1; repeat (2) cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("ph_count", hit_log.size(), 7);
        for (int i = 0; i < 7 && i < hit_log.size(); i++) chk("ph_seq", hit_log[i], ph_exp[i]);

        // Threshold 0 disables the flag
        clear_logs();
        persist_i = 8'd0; mode_i = 3'd1; valid_i = 1'b1;
        repeat (5) cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("p0_count", hit_log.size(), 5);
        for (int i = 0; i < hit_log.size(); i++) chk("p0_never", hit_log[i], 0);

        // Saturation: one false then 300 true, threshold at the counter maximum
        clear_logs();
        persist_i = 8'd255; valid_i = 1'b1;
        mode_i = 3'd0; cyc();
        mode_i = 3'd1; repeat (300) cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("sat_count", hit_log.size(), 301);
        if (hit_log.size() == 301) begin
            chk("sat_254", hit_log[254], 0);
            chk("sat_255", hit_log[255], 1);
            chk("sat_256_nowrap", hit_log[256], 1);
            chk("sat_300", hit_log[300], 1);
        end

        // clear_i with both stages full and a concurrent input
        clear_logs();
        persist_i = 8'd3; mode_i = 3'd1; valid_i = 1'b1; ready_i = 1'b1;
        repeat (2) cyc();
        ready_i = 1'b0;
        repeat (3) cyc();
        chk("clr_full_ready", s_rdy, 0);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        cyc();
        chk("clr_valid", s_vld, 0);
        chk("clr_ready", s_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("clr_dropped", s_vld, 0);
        end
        clear_logs();
        persist_i = 8'd2; valid_i = 1'b1;
        cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("clr_cnt_count", hit_log.size(), 1);
        if (hit_log.size() == 1) chk("clr_cnt_zero", hit_log[0], 0);

        // Asynchronous reset mid-stream while outputs are stalled
        persist_i = 8'd3; mode_i = 3'd1; valid_i = 1'b1; ready_i = 1'b1;
        repeat (4) cyc();
        ready_i = 1'b0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_any", any_o, 0);
        chk("arst_all", all_o, 0);
        chk("arst_hit", persist_hit_o, 0);
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete(); m_cnt = 0; prev_stall = 1'b0;
        ready_i = 1'b1;
        clear_logs();
        persist_i = 8'd2; valid_i = 1'b1;
        cyc();
        valid_i = 1'b0;
        repeat (3) cyc();
        chk("arst_cnt_count", hit_log.size(), 1);
        if (hit_log.size() == 1) chk("arst_cnt_zero", hit_log[0], 0);

        // Randomized stream against the reference model
        for (int i = 0; i < 600; i++) begin
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 3) != 0);
            clear_i  = ($urandom_range(0, 49) == 0);
            mode_i   = 3'($urandom_range(0, 7));
            signed_i = 1'($urandom_range(0, 1));
            persist_i = 8'($urandom_range(0, 3));
            for (int k = 0; k < L; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    A_i[k*DW +: DW] = 13'($urandom_range(0, 2));
                    B_i[k*DW +: DW] = 13'($urandom_range(0, 2));
                end else begin
                    A_i[k*DW +: DW] = 13'($urandom);
                    B_i[k*DW +: DW] = 13'($urandom);
                end
            end
            cyc();
        end
        clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (5) cyc();
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
